// File: rtl/ship_life_controller.sv
// rtl/ship_life_controller.sv - ship life, respawn, explosion and heading controller
// State, lives, heading and the status outputs are all registered; status flags follow the next state.
module ship_life_controller #(
  parameter int LIVES       = 3,
  parameter int DEAD_FRAMES = 120,
  parameter int ROT_FRAMES  = 4
) (
  input  logic       iPClk,
  input  logic       iRst,
  input  logic       iFrameTick,
  input  logic       iStart,
  input  logic       iLeft,
  input  logic       iRight,
  input  logic       iShipActive,
  output logic       oRestart,
  output logic [2:0] oAngle,
  output logic [1:0] oLives,
  output logic       oExplode,
  output logic       oGameOver
);

  localparam logic [1:0] LIVES_L    = 2'(LIVES);
  localparam logic [7:0] DEAD_L     = 8'(DEAD_FRAMES);
  localparam logic [3:0] ROT_LAST_L = 4'(ROT_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESPAWN,
    S_PLAY,
    S_DEAD,
    S_OVER
  } state_t;

  state_t     state_q, state_d;
  logic       start_q;
  logic       start_ev;
  logic [1:0] lives_q, lives_d;
  logic [2:0] angle_q, angle_d;
  logic [7:0] dead_cnt_q, dead_cnt_d;
  logic [3:0] rot_cnt_q, rot_cnt_d;
  logic       restart_q, explode_q, over_q;

  assign start_ev = iStart & ~start_q;

  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    angle_d    = angle_q;
    dead_cnt_d = dead_cnt_q;
    rot_cnt_d  = '0;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_ev) begin
          lives_d = LIVES_L;
          state_d = S_RESPAWN;
        end
      end
      S_RESPAWN: state_d = S_PLAY;
      S_PLAY: begin
        // A ship loss outranks any rotation step arriving on the same frame tick.
        if (!iShipActive) begin
          if (lives_q == 2'd0) begin
            state_d = S_OVER;
          end else begin
            lives_d    = lives_q - 2'd1;
            dead_cnt_d = DEAD_L;
            state_d    = S_DEAD;
          end
        end else if (iLeft ^ iRight) begin
          rot_cnt_d = rot_cnt_q;
          if (iFrameTick) begin
            if (rot_cnt_q == ROT_LAST_L) begin
              rot_cnt_d = '0;
              angle_d   = iLeft ? angle_q + 3'd1 : angle_q - 3'd1;
            end else begin
              rot_cnt_d = rot_cnt_q + 4'd1;
            end
          end
        end
      end
      S_DEAD: begin
        if (iFrameTick) begin
          if (dead_cnt_q <= 8'd1) begin
            dead_cnt_d = '0;
            state_d    = S_RESPAWN;
          end else begin
            dead_cnt_d = dead_cnt_q - 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_RESPAWN) begin
      angle_d = '0;
    end
  end

  always_ff @(posedge iPClk or negedge iRst) begin
    if (!iRst) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      lives_q    <= LIVES_L;
      angle_q    <= '0;
      dead_cnt_q <= '0;
      rot_cnt_q  <= '0;
      restart_q  <= 1'b0;
      explode_q  <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= iStart;
      lives_q    <= lives_d;
      angle_q    <= angle_d;
      dead_cnt_q <= dead_cnt_d;
      rot_cnt_q  <= rot_cnt_d;
      restart_q  <= (state_d == S_RESPAWN);
      explode_q  <= (state_d == S_DEAD);
      over_q     <= (state_d == S_OVER);
    end
  end

  assign oRestart  = restart_q;
  assign oAngle    = angle_q;
  assign oLives    = lives_q;
  assign oExplode  = explode_q;
  assign oGameOver = over_q;

endmodule

// File: tb/tb_ship_life_controller.sv
// tb/tb_ship_life_controller.sv - scoreboard bench for ship_life_controller
// Driver feeds a game-rule model per cycle; monitor pops expectations after each clock edge.
module tb_ship_life_controller;

  localparam int LIVES = 3;
  localparam int DEAD_FRAMES = 120;
  localparam int ROT_FRAMES = 4;

  localparam int M_IDLE = 0, M_RESPAWN = 1, M_PLAY = 2, M_DEAD = 3, M_OVER = 4;

  typedef struct packed {
    logic       restart;
    logic [2:0] angle;
    logic [1:0] lives;
    logic       explode;
    logic       over;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, start = 1'b0, left = 1'b0, right = 1'b0, ship = 1'b1;
  logic       restart, explode, over;
  logic [2:0] angle;
  logic [1:0] lives;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;

  int m_mode = M_IDLE, m_lives = LIVES, m_angle = 0, m_dead_left = 0, m_ticks_turning = 0;
  bit m_prev_start = 0;

  ship_life_controller #(
    .LIVES(LIVES), .DEAD_FRAMES(DEAD_FRAMES), .ROT_FRAMES(ROT_FRAMES)
  ) dut (
    .iPClk(clk), .iRst(rst_n), .iFrameTick(tick), .iStart(start),
    .iLeft(left), .iRight(right), .iShipActive(ship),
    .oRestart(restart), .oAngle(angle), .oLives(lives),
    .oExplode(explode), .oGameOver(over)
  );

  always #5 clk = ~clk;

  // Game rules for one clock edge, with the inputs that edge samples.
  task automatic model_step(input bit st, input bit l, input bit r, input bit sa, input bit ft, input bit rn);
    bit start_event;
    if (!rn) begin
      m_mode = M_IDLE; m_lives = LIVES; m_angle = 0; m_dead_left = 0;
      m_ticks_turning = 0; m_prev_start = 0;
      return;
    end
    start_event = st && !m_prev_start;
    m_prev_start = st;
    if (m_mode != M_PLAY) m_ticks_turning = 0;
    case (m_mode)
      M_IDLE, M_OVER: if (start_event) begin m_lives = LIVES; m_mode = M_RESPAWN; end
      M_RESPAWN: m_mode = M_PLAY;
      M_PLAY: begin
        if (!sa) begin
          m_ticks_turning = 0;
          if (m_lives == 0) m_mode = M_OVER;
          else begin m_lives = m_lives - 1; m_dead_left = DEAD_FRAMES; m_mode = M_DEAD; end
        end else if (l != r) begin
          if (ft) m_ticks_turning++;
          if (m_ticks_turning == ROT_FRAMES) begin
            m_ticks_turning = 0;
            m_angle = (m_angle + (l ? 1 : 7)) % 8;
          end
        end else begin
          m_ticks_turning = 0;
        end
      end
      M_DEAD: if (ft) begin
        m_dead_left--;
        if (m_dead_left == 0) m_mode = M_RESPAWN;
      end
      default: m_mode = M_IDLE;
    endcase
    if (m_mode == M_RESPAWN) m_angle = 0;
  endtask

  task automatic step(input bit st, input bit l, input bit r, input bit sa, input bit ft, input bit rn);
    exp_t e;
    @(negedge clk);
    start = st; left = l; right = r; ship = sa; tick = ft; rst_n = rn;
    model_step(st, l, r, sa, ft, rn);
    e.restart = (m_mode == M_RESPAWN);
    e.angle   = 3'(m_angle);
    e.lives   = 2'(m_lives);
    e.explode = (m_mode == M_DEAD);
    e.over    = (m_mode == M_OVER);
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e, got;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {restart, angle, lives, explode, over};
        n_vec++;
        if (got !== e) begin
          n_miss++;
          if (n_miss <= 40)
            $display("FAIL outputs cycle %0d: actual restart/angle/lives/explode/over=%b required %b",
                     cyc, got, e);
        end
      end
    end
  end

  initial begin : driver
    bit st, l, r, sa, rn;
    int ship_down, rst_hold;
    // Reset, then start: one restart pulse, PLAY with heading 0.
    repeat (3) step(0, 0, 0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 1, 0, 1);
    repeat (4) step(1, 0, 0, 1, 0, 1);
    // Left for 8 ticks, then right for 12 ticks.
    for (int i = 0; i < 16; i++) step(1, 1, 0, 1, i[0], 1);
    for (int i = 0; i < 24; i++) step(1, 0, 1, 1, i[0], 1);
    step(1, 0, 0, 1, 1, 1);
    // Three ticks of left, then a loss on the fourth tick.
    for (int i = 0; i < 6; i++) step(1, 1, 0, 1, i[0], 1);
    step(1, 1, 0, 0, 1, 1);
    // Explosion runs 70 ticks, then reset mid-explosion; no restart afterwards without a start.
    for (int i = 0; i < 140; i++) step(0, 0, 0, 1, i[0], 1);
    repeat (2) step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, i[0], 1);
    // Full game to OVER: every loss followed by a full explosion.
    step(1, 0, 0, 1, 0, 1);
    for (int k = 0; k < 4; k++) begin
      repeat (3) step(1, 0, 0, 1, 0, 1);
      step(1, 0, 0, 0, 1, 1);
      for (int i = 0; i < 250; i++) step(1, 0, 0, 1, i[0], 1);
    end
    repeat (3) step(0, 0, 0, 0, 1, 1);
    repeat (3) step(1, 0, 0, 1, 0, 1);
    // Randomized play.
    st = 0; l = 0; r = 0; ship_down = 0; rst_hold = 0;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 49) == 0) st = ~st;
      if ($urandom_range(0, 19) == 0) l = ~l;
      if ($urandom_range(0, 19) == 0) r = ~r;
      if (ship_down == 0 && $urandom_range(0, 59) == 0) ship_down = $urandom_range(1, 6);
      sa = (ship_down == 0);
      if (ship_down > 0) ship_down--;
      if (rst_hold == 0 && $urandom_range(0, 2999) == 0) rst_hold = $urandom_range(1, 3);
      rn = (rst_hold == 0);
      if (rst_hold > 0) rst_hold--;
      step(st, l, r, sa, ($urandom_range(0, 1) == 1), rn);
    end
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: actual %0d pending expectations required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
